// File: rtl/seq_comparator.sv
// Multi-cycle magnitude/equality comparator: scans CHUNK-bit slices MSB-first and
// stops at the first differing slice. Signed mode biases the sign bit so one unsigned scan serves both.
module seq_comparator #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  input  logic             signed_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             compout,
  output logic             err
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int IDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [IDX_W-1:0] IDX_TOP = IDX_W'(NCHUNK - 1);

  generate
    if ((WIDTH % CHUNK) != 0 || CHUNK < 1) begin : g_bad_chunk
      $error("seq_comparator: WIDTH must be an integer multiple of CHUNK");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             gt_q, gt_d, lt_q, lt_d, eq_q, eq_d;
  logic             compout_q, compout_d, err_q, err_d;
  logic [WIDTH-1:0] a_q, b_q;
  logic [2:0]       op_q;
  logic             load;
  logic [CHUNK-1:0] a_sl, b_sl;

  function automatic logic op_result(input logic [2:0] o, input logic g,
                                     input logic l, input logic e);
    case (o)
      3'd0:    op_result = e;
      3'd1:    op_result = g | e;
      3'd2:    op_result = l | e;
      3'd3:    op_result = g;
      3'd4:    op_result = l;
      3'd5:    op_result = ~e;
      default: op_result = 1'b0;
    endcase
  endfunction

  assign in_ready  = (state_q == IDLE) && !reset;
  assign out_valid = (state_q == DONE);
  assign compout   = compout_q;
  assign err       = err_q;

  assign a_sl = a_q[int'(idx_q)*CHUNK +: CHUNK];
  assign b_sl = b_q[int'(idx_q)*CHUNK +: CHUNK];

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    gt_d      = gt_q;
    lt_d      = lt_q;
    eq_d      = eq_q;
    compout_d = compout_q;
    err_d     = err_q;
    load      = 1'b0;
    case (state_q)
      IDLE: begin
        if (in_valid && in_ready) begin
          load = 1'b1;
          gt_d = 1'b0;
          lt_d = 1'b0;
          eq_d = 1'b0;
          idx_d = IDX_TOP;
          if (op > 3'd5) begin
            state_d   = DONE;
            err_d     = 1'b1;
            compout_d = 1'b0;
          end else begin
            state_d = SCAN;
          end
        end
      end
      SCAN: begin
        if (a_sl != b_sl) begin
          gt_d      = (a_sl > b_sl);
          lt_d      = (a_sl < b_sl);
          state_d   = DONE;
          compout_d = op_result(op_q, a_sl > b_sl, a_sl < b_sl, 1'b0);
        end else if (idx_q == '0) begin
          eq_d      = 1'b1;
          state_d   = DONE;
          compout_d = op_result(op_q, 1'b0, 1'b0, 1'b1);
        end else begin
          idx_d = idx_q - IDX_W'(1);
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d   = IDLE;
          compout_d = 1'b0;
          err_d     = 1'b0;
          gt_d      = 1'b0;
          lt_d      = 1'b0;
          eq_d      = 1'b0;
          idx_d     = IDX_TOP;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // control state
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= IDLE;
      idx_q     <= IDX_TOP;
      gt_q      <= 1'b0;
      lt_q      <= 1'b0;
      eq_q      <= 1'b0;
      compout_q <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      gt_q      <= gt_d;
      lt_q      <= lt_d;
      eq_q      <= eq_d;
      compout_q <= compout_d;
      err_q     <= err_d;
    end
  end

  // operand capture; sign-bit inversion maps two's complement onto unsigned order
  always_ff @(posedge clock) begin
    if (load) begin
      a_q  <= {a[WIDTH-1] ^ signed_mode, a[WIDTH-2:0]};
      b_q  <= {b[WIDTH-1] ^ signed_mode, b[WIDTH-2:0]};
      op_q <= op;
    end
  end

endmodule

// File: tb/tb_seq_comparator.sv
// Directed bench for seq_comparator (WIDTH=32, CHUNK=8).
module tb_seq_comparator;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic [2:0]  op = '0;
  logic        signed_mode = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic        compout;
  logic        err;

  int errors = 0;
  int checks = 0;

  seq_comparator #(.WIDTH(32), .CHUNK(8)) dut (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .op(op), .signed_mode(signed_mode), .out_valid(out_valid),
    .out_ready(out_ready), .compout(compout), .err(err)
  );

  always #5 clock = ~clock;

  // Issue one request and wait (bounded) for out_valid; the result is left held.
  // lat counts cycles so that a result visible right after the accept edge is 1.
  task automatic run_req(input logic [31:0] av, input logic [31:0] bv, input logic [2:0] opv,
                         input logic sm, output int lat, output logic cmp, output logic e);
    @(negedge clock);
    a = av; b = bv; op = opv; signed_mode = sm; in_valid = 1'b1;
    @(posedge clock); #1;
    in_valid = 1'b0;
    a = ~av; b = ~bv; op = 3'd5; signed_mode = ~sm;
    lat = 1;
    while (!out_valid && lat < 40) begin
      @(posedge clock); #1;
      lat++;
    end
    cmp = compout;
    e = err;
  endtask

  task automatic consume();
    @(negedge clock);
    out_ready = 1'b1;
    @(posedge clock); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    checks++; if (compout !== 1'b0) begin errors++; $display("FAIL reset_compout got=%b exp=0", compout); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err got=%b exp=0", err); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready_during got=%b exp=0", in_ready); end
    @(negedge clock);
    reset = 1'b0;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready_after got=%b exp=1", in_ready); end
  endtask

  task automatic test_equal_zero();
    int lat; logic c, e;
    run_req(32'h0, 32'h0, 3'b000, 1'b0, lat, c, e);
    checks++; if (c !== 1'b1) begin errors++; $display("FAIL eq_zero_compout got=%b exp=1", c); end
    checks++; if (e !== 1'b0) begin errors++; $display("FAIL eq_zero_err got=%b exp=0", e); end
    checks++; if (lat != 5) begin errors++; $display("FAIL eq_zero_latency got=%0d exp=5", lat); end
    consume();
    checks++; if (out_valid !== 1'b0 || compout !== 1'b0 || in_ready !== 1'b1) begin
      errors++; $display("FAIL eq_zero_release got ov=%b c=%b rdy=%b exp 0,0,1", out_valid, compout, in_ready);
    end
  endtask

  task automatic test_early_exit();
    int lat; logic c, e;
    run_req(32'h8000_0000, 32'h0000_0001, 3'b011, 1'b0, lat, c, e);
    checks++; if (c !== 1'b1) begin errors++; $display("FAIL early_unsigned_compout got=%b exp=1", c); end
    checks++; if (lat != 2) begin errors++; $display("FAIL early_unsigned_latency got=%0d exp=2", lat); end
    consume();
    run_req(32'h8000_0000, 32'h0000_0001, 3'b011, 1'b1, lat, c, e);
    checks++; if (c !== 1'b0) begin errors++; $display("FAIL early_signed_compout got=%b exp=0", c); end
    checks++; if (lat != 2) begin errors++; $display("FAIL early_signed_latency got=%0d exp=2", lat); end
    consume();
    run_req(32'hFFFF_FFFF, 32'h0000_0001, 3'b100, 1'b1, lat, c, e);
    checks++; if (c !== 1'b1) begin errors++; $display("FAIL signed_neg1_lt_1 got=%b exp=1", c); end
    consume();
  endtask

  task automatic test_op_sweep();
    logic [31:0] pa [3] = '{32'd0, 32'd1, 32'd0};
    logic [31:0] pb [3] = '{32'd0, 32'd0, 32'd1};
    // bit n = expected compout for op n: equal, greater, less
    logic [5:0]  exp_tab [3] = '{6'b000111, 6'b101010, 6'b110100};
    for (int p = 0; p < 3; p++) begin
      for (int o = 0; o < 6; o++) begin
        int lat; logic c, e; logic [5:0] row;
        row = exp_tab[p];
        run_req(pa[p], pb[p], 3'(o), 1'b0, lat, c, e);
        checks++; if (c !== row[o] || e !== 1'b0) begin
          errors++; $display("FAIL sweep_pair%0d_op%0d got c=%b e=%b exp c=%b e=0", p, o, c, e, row[o]);
        end
        checks++; if (lat != 5) begin errors++; $display("FAIL sweep_lat_pair%0d_op%0d got=%0d exp=5", p, o, lat); end
        consume();
      end
    end
  endtask

  task automatic test_illegal();
    for (int o = 6; o < 8; o++) begin
      int lat; logic c, e;
      run_req(32'h1234_5678, 32'h1234_5678, 3'(o), 1'b0, lat, c, e);
      checks++; if (e !== 1'b1 || c !== 1'b0) begin
        errors++; $display("FAIL illegal_op%0d got err=%b c=%b exp err=1 c=0", o, e, c);
      end
      checks++; if (lat != 1) begin errors++; $display("FAIL illegal_lat_op%0d got=%0d exp=1", o, lat); end
      consume();
      checks++; if (err !== 1'b0) begin errors++; $display("FAIL illegal_err_clear_op%0d got=%b exp=0", o, err); end
    end
  endtask

  task automatic test_backpressure();
    int lat; logic c, e; int bad;
    run_req(32'h0000_0005, 32'h0000_0005, 3'b000, 1'b0, lat, c, e);
    checks++; if (c !== 1'b1) begin errors++; $display("FAIL bp_initial_compout got=%b exp=1", c); end
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      a = 32'(i * 37); b = 32'(i); in_valid = i[0];
      @(posedge clock); #1;
      if (out_valid !== 1'b1 || compout !== 1'b1 || in_ready !== 1'b0) bad++;
    end
    @(negedge clock);
    in_valid = 1'b0;
    checks++; if (bad != 0) begin errors++; $display("FAIL bp_hold got=%0d bad cycles exp=0", bad); end
    consume();
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++; $display("FAIL bp_release got ov=%b rdy=%b exp 0,1", out_valid, in_ready);
    end
    repeat (3) @(posedge clock);
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_no_second_accept got ov=%b exp=0", out_valid); end
  endtask

  task automatic test_reset_abort();
    int lat; logic c, e; int stale;
    @(negedge clock);
    a = 32'h0; b = 32'h0; op = 3'b000; signed_mode = 1'b0; in_valid = 1'b1;
    @(posedge clock); #1;
    in_valid = 1'b0;
    @(posedge clock); #1;
    reset = 1'b1;
    @(posedge clock); #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL abort_out_valid got=%b exp=0", out_valid); end
    reset = 1'b0;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL abort_in_ready got=%b exp=1", in_ready); end
    stale = 0;
    repeat (6) begin
      @(posedge clock); #1;
      if (out_valid !== 1'b0) stale++;
    end
    checks++; if (stale != 0) begin errors++; $display("FAIL abort_stale_result got=%0d exp=0", stale); end
    run_req(32'h0000_0100, 32'h0000_00FF, 3'b011, 1'b0, lat, c, e);
    checks++; if (c !== 1'b1 || lat != 4) begin
      errors++; $display("FAIL abort_followup got c=%b lat=%0d exp c=1 lat=4", c, lat);
    end
    consume();
  endtask

  task automatic test_back_to_back();
    int lat; logic c, e;
    run_req(32'h7F00_0000, 32'h8000_0000, 3'b100, 1'b0, lat, c, e);
    checks++; if (c !== 1'b1 || lat != 2) begin
      errors++; $display("FAIL b2b_first got c=%b lat=%0d exp c=1 lat=2", c, lat);
    end
    consume();
    run_req(32'h7F00_0000, 32'h8000_0000, 3'b100, 1'b1, lat, c, e);
    checks++; if (c !== 1'b0 || lat != 2) begin
      errors++; $display("FAIL b2b_second got c=%b lat=%0d exp c=0 lat=2", c, lat);
    end
    consume();
  endtask

  initial begin
    test_reset();
    test_equal_zero();
    test_early_exit();
    test_op_sweep();
    test_illegal();
    test_backpressure();
    test_reset_abort();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/seq_comparator.md
Name: seq_comparator

Overview:
- Multi-cycle, parametrised successor to the 32-bit combinational Comparator.
- Compares operands a and b one CHUNK-bit slice per cycle, most significant slice first, and exits early on the first differing slice.
- Adds a signed/unsigned mode, an illegal-op error flag, and valid/ready handshakes on input and output.
- Sits beside the ALU as the branch-condition unit when WIDTH is large enough that a single-cycle compare does not close timing.

Parameters:
- WIDTH, 32, operand width in bits.
- CHUNK, 8, bits compared per cycle. WIDTH must be an integer multiple of CHUNK; any other value is an elaboration error.
- NCHUNK (localparam), WIDTH/CHUNK, number of slices.

Ports:
- clock  in  1  single clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  request valid.
- in_ready  out  1  block can accept a request.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- op  in  3  000 a==b, 001 a>=b, 010 a<=b, 011 a>b, 100 a<b, 101 a!=b, 110/111 illegal.
- signed_mode  in  1  1 = two's-complement compare, 0 = unsigned.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- compout  out  1  comparison result.
- err  out  1  illegal op flag; qualified by out_valid.

Behaviour:
- Clocking: one clock; reset is synchronous and active-high.
- Reset: state=IDLE; out_valid=0, compout=0, err=0; internal gt/lt/eq flags cleared; slice index=NCHUNK-1.
- in_ready = (state==IDLE) && !reset. It is combinational from the state register.
- A reset asserted in any state takes effect on the next edge and aborts the operation in flight. No result is produced for it.
- States: IDLE, SCAN, DONE.
- IDLE:
  - Accept when in_valid && in_ready.
  - Register a, b, op and signed_mode.
  - If signed_mode=1, invert bit WIDTH-1 of both registered operands. The compare is then unsigned.
  - Legal op: go to SCAN with index=NCHUNK-1.
  - Illegal op: go to DONE directly with err=1, compout=0.
- SCAN, one slice per cycle:
  - Compare a_r[idx*CHUNK +: CHUNK] against b_r[idx*CHUNK +: CHUNK].
  - Slices differ: set gt or lt and go to DONE.
  - Slices equal and idx==0: set eq and go to DONE.
  - Otherwise: decrement idx and stay in SCAN.
- Result registration: compout and err are registered on entry to DONE.
  - compout = eq for 000, gt|eq for 001, lt|eq for 010, gt for 011, lt for 100, !eq for 101.
- DONE:
  - out_valid=1.
  - compout and err hold stable until out_valid && out_ready.
  - On that handshake the next state is IDLE, out_valid drops, and compout/err return to 0.
- Latency: accept at edge T; k SCAN cycles, where k is the 1-based position (from the MSB) of the first differing slice, or NCHUNK if all slices are equal.
  - out_valid is first high in cycle T+k+1.
  - An illegal op has out_valid high in cycle T+1.
- Throughput: at most one request per k+2 cycles. No request is accepted in the cycle a result is consumed, because in_ready is 0 in DONE.
- Inputs a, b, op and signed_mode are ignored when not accepted. Changes to them after acceptance do not affect the operation in flight.
- Back-pressure: out_ready held low keeps the block in DONE indefinitely with stable outputs.
- in_valid while busy is ignored; no request is queued.

Test Plan:
- WIDTH=32, CHUNK=8, unsigned; a=0, b=0, op=000 -> compout=1, err=0; out_valid 5 cycles after accept (4 SCAN cycles).
- a=32'h8000_0000, b=32'h0000_0001, op=011: unsigned -> compout=1 with out_valid at T+2 (early exit on slice 3). Same operands signed -> compout=0.
- Sweep all six legal ops over pairs (0,0), (1,0), (0,1) -> results match the op table (for example, op=101 gives 0,1,1). For (1,0) and (0,1), out_valid at T+5 because the difference is in slice 0.
- op=110 -> err=1, compout=0, out_valid at T+1; op=111 gives the same.
- Hold out_ready=0 for 10 cycles in DONE while toggling a, b and in_valid -> compout stable, in_ready=0, no second accept. Release out_ready -> IDLE next cycle and in_ready=1.
- Assert reset in the 2nd SCAN cycle of a full-equal compare -> next cycle out_valid=0, in_ready=1 after reset drops, no stale result. A new request then completes normally.
